// File: rtl/clock_pkg.sv
// Shared constants for the clock display path: field encoding, error nibble,
// digit count and the digit-slot to field mapping.
package clock_pkg;

   typedef enum logic [1:0] {
      FIELD_NONE = 2'd0,
      FIELD_H    = 2'd1,
      FIELD_M    = 2'd2,
      FIELD_S    = 2'd3
   } field_e;

   localparam logic [3:0] ERR_NIBBLE = 4'hE;
   localparam int         NUM_DIGITS = 6;

   // Slots 0/1 are hours, 2/3 minutes, 4/5 seconds.
   function automatic field_e field_of_digit(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1: return FIELD_H;
         3'd2, 3'd3: return FIELD_M;
         default:    return FIELD_S;
      endcase
   endfunction

endpackage

// File: rtl/display_scan_if.sv
// Time inputs and multiplexed 7-segment outputs of the display scanner.
// Handshake-free: inputs are levels sampled at slot ticks, outputs are registered levels.
interface display_scan_if;

   logic [4:0] countH;
   logic [5:0] countM;
   logic [6:0] countS;
   logic [1:0] blinkSel;
   logic [6:0] seg;
   logic [5:0] an;
   logic       dp;

   modport master (
      output countH, countM, countS, blinkSel,
      input  seg, an, dp
   );

   modport slave (
      input  countH, countM, countS, blinkSel,
      output seg, an, dp
   );

endinterface

// File: rtl/dec7seg.sv
// Hex nibble to active-high 7-segment pattern, bit order {a,b,c,d,e,f,g}.
module dec7seg (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'b0000000;
      case (nibble)
         4'h0: seg = 7'b1111110;
         4'h1: seg = 7'b0110000;
         4'h2: seg = 7'b1101101;
         4'h3: seg = 7'b1111001;
         4'h4: seg = 7'b0110011;
         4'h5: seg = 7'b1011011;
         4'h6: seg = 7'b1011111;
         4'h7: seg = 7'b1110000;
         4'h8: seg = 7'b1111111;
         4'h9: seg = 7'b1111011;
         4'hA: seg = 7'b1110111;
         4'hB: seg = 7'b0011111;
         4'hC: seg = 7'b1001110;
         4'hD: seg = 7'b0111101;
         4'hE: seg = 7'b1001111;
         default: seg = 7'b1000111;
      endcase
   end

endmodule

// File: rtl/display_scan.sv
// Six-digit HH:MM:SS multiplexed display scanner with frame-consistent
// snapshots, out-of-range error digits and per-field blinking.
module display_scan
   import clock_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input logic           clock,
   input logic           reset,
   display_scan_if.slave bus
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
   localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [FW-1:0] frame_q, frame_d;
   logic          phase_q, phase_d;
   logic [4:0]    snap_h_q, snap_h_d;
   logic [5:0]    snap_m_q, snap_m_d;
   logic [6:0]    snap_s_q, snap_s_d;
   logic [5:0]    an_q, an_d;
   logic [3:0]    nib_q, nib_d;
   logic          dp_q, dp_d;

   logic       tick;
   logic       wrap;
   field_e     fld;
   logic [6:0] val;
   logic [6:0] lim;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       blank;

   always_comb begin
      tick     = (cnt_q == CNT_LAST);
      wrap     = tick && (idx_q == IDX_LAST);
      cnt_d    = tick ? '0 : cnt_q + CW'(1);
      idx_d    = idx_q;
      frame_d  = frame_q;
      phase_d  = phase_q;
      snap_h_d = snap_h_q;
      snap_m_d = snap_m_q;
      snap_s_d = snap_s_q;
      an_d     = an_q;
      nib_d    = nib_q;
      dp_d     = dp_q;

      if (tick) begin
         idx_d = wrap ? 3'd0 : idx_q + 3'd1;
      end

      // The wrap tick both captures the new frame and displays its first digit,
      // so downstream decode reads the *_d snapshot values.
      if (wrap) begin
         snap_h_d = bus.countH;
         snap_m_d = bus.countM;
         snap_s_d = bus.countS;
         if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            phase_d = ~phase_q;
         end else begin
            frame_d = frame_q + FW'(1);
         end
      end

      fld = field_of_digit(idx_d);
      val = '0;
      lim = '0;
      case (fld)
         FIELD_H: begin
            val = {2'b00, snap_h_d};
            lim = 7'd23;
         end
         FIELD_M: begin
            val = {1'b0, snap_m_d};
            lim = 7'd59;
         end
         default: begin
            val = snap_s_d;
            lim = 7'd59;
         end
      endcase
      tens  = 4'(val / 7'd10);
      ones  = 4'(val % 7'd10);
      blank = phase_d && (field_e'(bus.blinkSel) == fld);

      if (tick) begin
         an_d  = blank ? 6'b000000 : (6'b000001 << idx_d);
         nib_d = (val > lim) ? ERR_NIBBLE : (idx_d[0] ? ones : tens);
         dp_d  = (idx_d == 3'd1) || (idx_d == 3'd3);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         frame_q  <= '0;
         phase_q  <= 1'b0;
         snap_h_q <= '0;
         snap_m_q <= '0;
         snap_s_q <= '0;
         an_q     <= 6'b000001;
         nib_q    <= '0;
         dp_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         frame_q  <= frame_d;
         phase_q  <= phase_d;
         snap_h_q <= snap_h_d;
         snap_m_q <= snap_m_d;
         snap_s_q <= snap_s_d;
         an_q     <= an_d;
         nib_q    <= nib_d;
         dp_q     <= dp_d;
      end
   end

   dec7seg u_dec7seg (
      .nibble (nib_q),
      .seg    (bus.seg)
   );

   assign bus.an = an_q;
   assign bus.dp = dp_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: directed scenarios plus randomized time values, all
// checked against a slot/frame arithmetic reference model.
module tb_display_scan;

   localparam int SCAN_DIV     = 4;
   localparam int BLINK_FRAMES = 2;
   localparam int FRAME_CYC    = SCAN_DIV * 6;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [6:0] exp_q[$];

   display_scan_if bus ();

   display_scan #(
      .SCAN_DIV     (SCAN_DIV),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1111110;
         4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;
         4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;
         4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;
         4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1111011;
         4'hE: return 7'b1001111;
         default: return 7'bxxxxxxx;
      endcase
   endfunction

   function automatic logic [3:0] model_nib(input int slot, input int h, input int m, input int s);
      int d, v, lim;
      d   = slot % 6;
      v   = (d < 2) ? h : ((d < 4) ? m : s);
      lim = (d < 2) ? 23 : 59;
      if (v > lim) return 4'hE;
      return (d % 2 == 0) ? 4'(v / 10) : 4'(v % 10);
   endfunction

   function automatic logic [5:0] model_an(input int slot, input int sel);
      int d, frame;
      bit blank;
      d     = slot % 6;
      frame = slot / 6;
      blank = ((frame / BLINK_FRAMES) % 2 == 1) && (sel != 0) && (sel == d / 2 + 1);
      return blank ? 6'b000000 : 6'(1 << d);
   endfunction

   int         m_cyc;
   int         m_h, m_m, m_s;
   int         nxt_cyc, nxt_slot;
   logic [5:0] exp_an;
   logic [3:0] exp_nib;
   logic       exp_dp;
   logic [6:0] exp_seg;

   always_comb begin
      nxt_cyc  = m_cyc + 1;
      nxt_slot = nxt_cyc / SCAN_DIV;
      exp_seg  = seg_of(exp_nib);
   end

   // m_cyc counts edges since the last reset edge; slot k starts at edge k*SCAN_DIV.
   always @(posedge clock) begin
      if (reset) begin
         m_cyc   <= 0;
         m_h     <= 0;
         m_m     <= 0;
         m_s     <= 0;
         exp_an  <= 6'b000001;
         exp_nib <= 4'h0;
         exp_dp  <= 1'b0;
      end else begin
         m_cyc <= nxt_cyc;
         if (nxt_cyc % SCAN_DIV == 0) begin
            exp_an <= model_an(nxt_slot, int'(bus.blinkSel));
            exp_dp <= (nxt_slot % 6 == 1) || (nxt_slot % 6 == 3);
            if (nxt_slot % 6 == 0) begin
               m_h     <= int'(bus.countH);
               m_m     <= int'(bus.countM);
               m_s     <= int'(bus.countS);
               exp_nib <= model_nib(nxt_slot, int'(bus.countH), int'(bus.countM), int'(bus.countS));
            end else begin
               exp_nib <= model_nib(nxt_slot, m_h, m_m, m_s);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   task automatic set_time(input int h, input int m, input int s);
      bus.countH = 5'(h);
      bus.countM = 6'(m);
      bus.countS = 7'(s);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic wait_slot(input int d);
      int guard;
      guard = 0;
      do begin
         step(1);
         guard++;
      end while (!((m_cyc % SCAN_DIV == 0) && ((m_cyc / SCAN_DIV) % 6 == d)) && guard < 2 * FRAME_CYC);
      if (guard >= 2 * FRAME_CYC) begin
         checks++;
         errors++;
         $display("FAIL wait_slot: slot %0d not reached within %0d cycles", d, guard);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      set_time(0, 0, 0);
      bus.blinkSel = 2'd0;
      do_reset();
      checks++;
      if (bus.an !== 6'b000001) begin errors++; $display("FAIL reset_an: got %b expected %b", bus.an, 6'b000001); end
      checks++;
      if (bus.seg !== 7'b1111110) begin errors++; $display("FAIL reset_seg: got %b expected %b", bus.seg, 7'b1111110); end
      checks++;
      if (bus.dp !== 1'b0) begin errors++; $display("FAIL reset_dp: got %b expected 0", bus.dp); end
   endtask

   task automatic test_scan_order();
      logic [5:0] want_an;
      do_reset();
      for (int i = 1; i <= 24; i++) begin
         step(1);
         want_an = 6'(1 << ((i / SCAN_DIV) % 6));
         checks++;
         if (bus.an !== want_an) begin errors++; $display("FAIL scan_an: cycle %0d got %b expected %b", i, bus.an, want_an); end
         checks++;
         if (bus.dp !== exp_dp) begin errors++; $display("FAIL scan_dp: cycle %0d got %b expected %b", i, bus.dp, exp_dp); end
         checks++;
         if (bus.seg !== exp_seg) begin errors++; $display("FAIL scan_seg: cycle %0d got %b expected %b", i, bus.seg, exp_seg); end
      end
   endtask

   task automatic test_digits();
      int vals[3];
      logic [6:0] want;
      vals = '{12, 34, 56};
      set_time(12, 34, 56);
      wait_slot(0);
      exp_q.delete();
      for (int f = 0; f < 3; f++) begin
         exp_q.push_back(seg_of(4'(vals[f] / 10)));
         exp_q.push_back(seg_of(4'(vals[f] % 10)));
      end
      checks++;
      if (bus.seg !== 7'b0110000) begin errors++; $display("FAIL digits_slot0_seg: got %b expected %b", bus.seg, 7'b0110000); end
      for (int d = 0; d < 6; d++) begin
         want = exp_q.pop_front();
         checks++;
         if (bus.seg !== want) begin errors++; $display("FAIL digits_seg: slot %0d got %b expected %b", d, bus.seg, want); end
         step(SCAN_DIV);
      end
   endtask

   task automatic test_no_tear();
      int nxt[6];
      logic [6:0] want;
      nxt = '{2, 3, 5, 9, 5, 9};
      set_time(12, 34, 56);
      wait_slot(3);
      set_time(23, 59, 59);
      wait_slot(4);
      checks++;
      if (bus.seg !== seg_of(4'h5)) begin errors++; $display("FAIL tear_slot4: got %b expected %b", bus.seg, seg_of(4'h5)); end
      step(SCAN_DIV);
      checks++;
      if (bus.seg !== seg_of(4'h6)) begin errors++; $display("FAIL tear_slot5: got %b expected %b", bus.seg, seg_of(4'h6)); end
      exp_q.delete();
      for (int d = 0; d < 6; d++) exp_q.push_back(seg_of(4'(nxt[d])));
      for (int d = 0; d < 6; d++) begin
         step(SCAN_DIV);
         want = exp_q.pop_front();
         checks++;
         if (bus.seg !== want) begin errors++; $display("FAIL tear_next: slot %0d got %b expected %b", d, bus.seg, want); end
      end
   endtask

   task automatic test_error();
      int want_nib[6];
      want_nib = '{1, 2, 3, 4, 14, 14};
      set_time(12, 34, 100);
      wait_slot(0);
      for (int d = 0; d < 6; d++) begin
         checks++;
         if (bus.seg !== seg_of(4'(want_nib[d]))) begin
            errors++;
            $display("FAIL error_seg: slot %0d got %b expected %b", d, bus.seg, seg_of(4'(want_nib[d])));
         end
         if (d == 4) begin
            checks++;
            if (bus.seg !== 7'b1001111) begin errors++; $display("FAIL error_e_pattern: got %b expected %b", bus.seg, 7'b1001111); end
         end
         step(SCAN_DIV);
      end
   endtask

   task automatic test_blink();
      int fr;
      logic [5:0] want;
      set_time(12, 34, 56);
      bus.blinkSel = 2'd2;
      do_reset();
      for (int i = 1; i <= 8 * FRAME_CYC; i++) begin
         step(1);
         checks++;
         if (bus.an !== exp_an) begin errors++; $display("FAIL blink_an: cycle %0d got %b expected %b", i, bus.an, exp_an); end
         fr = i / FRAME_CYC;
         if (i % FRAME_CYC == 2 * SCAN_DIV || i % FRAME_CYC == 3 * SCAN_DIV) begin
            want = (fr == 2 || fr == 3 || fr == 6 || fr == 7) ? 6'b000000
                 : ((i % FRAME_CYC == 2 * SCAN_DIV) ? 6'b000100 : 6'b001000);
            checks++;
            if (bus.an !== want) begin errors++; $display("FAIL blink_min_slot: frame %0d got %b expected %b", fr + 1, bus.an, want); end
         end
      end
      bus.blinkSel = 2'd0;
      for (int i = 1; i <= 4 * FRAME_CYC; i++) begin
         step(1);
         checks++;
         if (bus.an !== exp_an) begin errors++; $display("FAIL noblink_an: cycle %0d got %b expected %b", i, bus.an, exp_an); end
         checks++;
         if (bus.an === 6'b000000) begin errors++; $display("FAIL noblink_blank: cycle %0d got %b expected nonzero", i, bus.an); end
      end
   endtask

   task automatic test_reset_mid();
      set_time(12, 34, 56);
      wait_slot(4);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      checks++;
      if (bus.an !== 6'b000001) begin errors++; $display("FAIL midreset_an: got %b expected %b", bus.an, 6'b000001); end
      checks++;
      if (bus.seg !== 7'b1111110) begin errors++; $display("FAIL midreset_seg: got %b expected %b", bus.seg, 7'b1111110); end
      checks++;
      if (bus.dp !== 1'b0) begin errors++; $display("FAIL midreset_dp: got %b expected 0", bus.dp); end
      for (int i = 1; i <= 4; i++) begin
         step(1);
         checks++;
         if (i < 4 && bus.an !== 6'b000001) begin
            errors++; $display("FAIL midreset_hold: cycle %0d got %b expected %b", i, bus.an, 6'b000001);
         end else if (i == 4 && (bus.an !== 6'b000010 || bus.dp !== 1'b1)) begin
            errors++; $display("FAIL midreset_advance: got an=%b dp=%b expected an=000010 dp=1", bus.an, bus.dp);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            set_time(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 127)));
         end
         if ($urandom_range(0, 15) == 0) bus.blinkSel = 2'($urandom_range(0, 3));
         reset = ($urandom_range(0, 299) == 0);
         step(1);
         checks++;
         if (bus.an !== exp_an) begin errors++; $display("FAIL rand_an: iter %0d got %b expected %b", i, bus.an, exp_an); end
         checks++;
         if (bus.seg !== exp_seg) begin errors++; $display("FAIL rand_seg: iter %0d got %b expected %b", i, bus.seg, exp_seg); end
         checks++;
         if (bus.dp !== exp_dp) begin errors++; $display("FAIL rand_dp: iter %0d got %b expected %b", i, bus.dp, exp_dp); end
      end
      reset = 1'b0;
   endtask

   initial begin
      set_time(0, 0, 0);
      bus.blinkSel = 2'd0;
      test_reset();
      test_scan_order();
      test_digits();
      test_no_tear();
      test_error();
      test_blink();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit slot (minimum 2).
REQ-002 SHALL have parameter BLINK_FRAMES, default 64: complete 6-digit frames per blink half-period (minimum 1).
REQ-003 SHALL have port clock  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port countH  in  5  hours value, binary, legal 0..23.
REQ-006 SHALL have port countM  in  6  minutes value, binary, legal 0..59.
REQ-007 SHALL have port countS  in  7  seconds value, binary, legal 0..59.
REQ-008 SHALL have port blinkSel  in  2  blinking field: 0 none, 1 hours, 2 minutes, 3 seconds.
REQ-009 SHALL have port seg  out  7  segment pattern of the active digit, active-high, in dec7seg bit order.
REQ-010 SHALL have port an  out  6  one-hot digit enable, active-high; bit 0 = hours tens, bit 5 = seconds ones.
REQ-011 SHALL have port dp  out  1  separator dot, active-high.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; a slot tick SHALL occur in the cycle where the count is SCAN_DIV-1.
REQ-013 On each slot tick, the digit index SHALL advance 0->1->...->5->0; the index SHALL hold between ticks.
REQ-014 Digit mapping SHALL be: 0 H tens, 1 H ones, 2 M tens, 3 M ones, 4 S tens, 5 S ones.
REQ-015 On the tick where the index wraps 5->0, countH/countM/countS SHALL be captured into snapshot registers; all six digits of a frame SHALL come from one snapshot, so no torn display.
REQ-016 Each field SHALL be split as tens = value/10 and ones = value%10, each 4 bits.
REQ-017 A snapshot field above its legal maximum (H>23, M>59, S>59) SHALL display both digits as 4'hE.
REQ-018 an, the digit nibble and dp SHALL be registered and SHALL update in the cycle after the tick; seg SHALL be the combinational decode of the registered nibble, giving one clock of latency from tick to visible output.
REQ-019 dp SHALL be 1 only while index 1 or 3 is active.
REQ-020 Blink phase SHALL toggle when the frame counter reaches BLINK_FRAMES-1 at a 5->0 wrap; the frame counter then SHALL return to 0.
REQ-021 While blink phase = 1 and blinkSel selects a field, an SHALL be 0 for that field's two slots; seg and dp SHALL still follow the decode.
REQ-022 blinkSel SHALL be sampled live each slot, not snapshotted; blinkSel = 0 SHALL never blank.

Reset
REQ-023 While reset = 1 at a clock edge: prescaler, index, frame counter and blink phase SHALL be 0, and snapshots SHALL be 0.
REQ-024 Outputs after reset SHALL be an = 6'b000001, nibble = 0 (seg = 7'b1111110), dp = 0.
REQ-025 Reset asserted mid-frame SHALL abort the scan; the first slot tick after release SHALL occur SCAN_DIV cycles after the release edge.

Structure
REQ-026 Field-select encoding (FIELD_NONE/H/M/S), the error nibble 4'hE and the digit-count constant 6 SHALL live in shared package clock_pkg.
REQ-027 Segment decode SHALL use one instance of the existing dec7seg sub-module; BCD split and scan logic SHALL be inline.

Verification (SCAN_DIV = 4, BLINK_FRAMES = 2)
REQ-028 Reset release, then 24 cycles -> an steps 000001,000010,...,100000,000001 every 4 cycles; dp = 1 only at 000010 and 001000.
REQ-029 H = 12, M = 34, S = 56 held -> nibbles in a frame are 1,2,3,4,5,6; seg at slot 0 = 7'b0110000.
REQ-030 Inputs change from 12:34:56 to 23:59:59 while index = 3 -> slots 4 and 5 still show 5,6; the next frame shows 2,3,5,9,5,9.
REQ-031 S = 100 -> slots 4 and 5 show nibble E (seg = 7'b1001111); slots 0..3 unaffected.
REQ-032 blinkSel = 2 -> an bits 2 and 3 are 0 in frames 3-4, 7-8, ... and present in frames 1-2, 5-6, ...; blinkSel = 0 -> no blanking.
REQ-033 Reset pulsed while index = 4 -> next cycle an = 000001, seg = 7'b1111110; the next advance occurs 4 cycles after release.
